sdram_bist: RTL and testbench
=============================

SDRAM_BIST -- requirements
Module: sdram_bist

Interface
REQ-001 Parameters SHALL be: DATA_W, default 16, data word width.
REQ-002 ADDR_W, default 22, word address width.
REQ-003 BASE_ADDR, default 0, first tested address.
REQ-004 NUM_WORDS, default 256, words per pass, range 1..2^ADDR_W.
REQ-005 ERR_W, default 16, error counter width.
REQ-006 BLINK_DIV, default 25000000, clk cycles per LED toggle on pass.
REQ-007 clk  in  1  single clock; all logic on rising edge.
REQ-008 rst  in  1  synchronous, active-high reset.
REQ-009 start  in  1  one-cycle pulse; begins test when idle.
REQ-010 mode  in  2  pattern: 0 constant 0xA5A5.., 1 address, 2 walking-one, 3 inverted address.
REQ-011 loop_en  in  1  repeat passes until stop.
REQ-012 stop  in  1  abort after current transaction completes.
REQ-013 wr_req  out  1  write request to SDRAM controller.
REQ-014 rd_req  out  1  read request to SDRAM controller.
REQ-015 addr  out  ADDR_W  transaction address.
REQ-016 wdata  out  DATA_W  write data.
REQ-017 wr_ack  in  1  controller accepted write.
REQ-018 rd_valid  in  1  read data returned; ends read request.
REQ-019 rdata  in  DATA_W  read data, valid with rd_valid.
REQ-020 busy  out  1  test in progress.
REQ-021 done  out  1  one-cycle pulse at end of test.
REQ-022 pass  out  1  sticky: last finished test had zero errors.
REQ-023 err_count  out  ERR_W  mismatches, saturating.
REQ-024 first_err_addr  out  ADDR_W  address of first mismatch.
REQ-025 led  out  1  blinks on pass, steady off on fail, steady on while busy.

Function
REQ-026 FSM states SHALL be IDLE, WRITE, READ, CHECK, FINISH.
REQ-027 IDLE->WRITE on start; start ignored outside IDLE; mode latched at start.
REQ-028 WRITE: wr_req=1 with addr/wdata stable until wr_ack; on wr_ack, addr increments the same cycle; after NUM_WORDS acks -> READ with addr=BASE_ADDR.
REQ-029 READ: rd_req=1 with addr stable until rd_valid; rdata captured, -> CHECK.
REQ-030 CHECK (one cycle): compare captured rdata with the regenerated expected pattern; on mismatch increment err_count (saturate at all-ones) and load first_err_addr if err_count was 0; next READ, or FINISH after word NUM_WORDS-1.
REQ-031 Never wr_req and rd_req high together; at most one transaction outstanding.
REQ-032 Pattern for word index i: mode0 constant 0xA5 repeated to DATA_W; mode1 addr zero-extended/truncated to DATA_W; mode2 1<<(i mod DATA_W); mode3 bitwise inverse of mode1.
REQ-033 Address arithmetic SHALL wrap modulo 2^ADDR_W; BASE_ADDR+NUM_WORDS overflow wraps to 0.
REQ-034 FINISH: done pulses one cycle; pass=(err_count==0); if loop_en and not stop -> WRITE with err_count kept accumulating, else -> IDLE.
REQ-035 stop in WRITE/READ: pending handshake completes, then FINISH with pass computed over words checked; stop in IDLE ignored.
REQ-036 wr_ack/rd_valid received outside the matching state SHALL be ignored.
REQ-037 led: busy -> 1; pass -> toggles every BLINK_DIV cycles; otherwise 0.
REQ-038 err_count and first_err_addr clear on start from IDLE, hold otherwise.

Reset
REQ-039 rst SHALL force IDLE, wr_req=0, rd_req=0, addr=BASE_ADDR, wdata=0, busy=0, done=0, pass=0, err_count=0, first_err_addr=0, led=0, blink counter 0.
REQ-040 rst mid-transaction SHALL drop requests next edge without waiting for ack.

Structure
REQ-041 Package sdram_bist_pkg SHALL hold the state enum and mode code constants.
REQ-042 LED blink counter SHALL be sub-module sdram_bist_blink (enable, period parameter, toggle output).

Verification
REQ-043 Defaults, mode1, ideal model acking in 2 cycles -> 256 writes then 256 reads, done pulse, pass=1, err_count=0, led blinking.
REQ-044 Model corrupts word at addr 5 (bit 0 flipped), mode0 -> err_count=1, first_err_addr=5, pass=0, led=0.
REQ-045 NUM_WORDS=4, BASE_ADDR=2^22-2 -> addresses 3FFFFE,3FFFFF,0,1 written and read.
REQ-046 loop_en=1, stop asserted during second pass read -> read completes, done pulse, return to IDLE, no further requests.
REQ-047 rst asserted while wr_req high and ack withheld -> wr_req=0 next cycle, all outputs at reset values.
REQ-048 Stuck-at-0 model, mode2, DATA_W=16, NUM_WORDS=20 -> err_count=20, first_err_addr=BASE_ADDR; err_count saturation checked with ERR_W=3 (stays 7).

Source files
------------

// File: rtl/sdram_bist_pkg.sv
// Shared types for the SDRAM built-in self test: FSM states and pattern mode codes.
package sdram_bist_pkg;
    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_CHECK, S_FINISH} state_t;

    localparam logic [1:0] MODE_CONST = 2'd0;
    localparam logic [1:0] MODE_ADDR  = 2'd1;
    localparam logic [1:0] MODE_WALK  = 2'd2;
    localparam logic [1:0] MODE_NADDR = 2'd3;

    localparam logic [7:0] CONST_BYTE = 8'hA5;
endpackage

// File: rtl/sdram_bist_if.sv
// Request/acknowledge bus between the BIST engine and an SDRAM controller.
interface sdram_bist_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 22
);
    logic              wr_req;
    logic              rd_req;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              wr_ack;
    logic              rd_valid;
    logic [DATA_W-1:0] rdata;

    modport master (output wr_req, rd_req, addr, wdata, input wr_ack, rd_valid, rdata);
    modport slave  (input wr_req, rd_req, addr, wdata, output wr_ack, rd_valid, rdata);
endinterface

// File: rtl/sdram_bist_blink.sv
// Free-running toggle used for the pass LED; held cleared while disabled.
module sdram_bist_blink #(
    parameter int PERIOD = 25000000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    output logic o_tog
);
    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic [CW-1:0] r_cnt;
    logic          r_tog;

    always_ff @(posedge clk) begin
        if (rst || !i_en) begin
            r_cnt <= '0;
            r_tog <= 1'b0;
        end else if (r_cnt == CW'(PERIOD - 1)) begin
            r_cnt <= '0;
            r_tog <= ~r_tog;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tog = r_tog;
endmodule

// File: rtl/sdram_bist.sv
// Write-then-verify memory test: fills NUM_WORDS with a pattern, reads back, counts mismatches.
module sdram_bist
    import sdram_bist_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 22,
    parameter int BASE_ADDR = 0,
    parameter int NUM_WORDS = 256,
    parameter int ERR_W     = 16,
    parameter int BLINK_DIV = 25000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [1:0]        i_mode,
    input  logic              i_loop_en,
    input  logic              i_stop,
    sdram_bist_if.master      bus,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_pass,
    output logic [ERR_W-1:0]  o_err_count,
    output logic [ADDR_W-1:0] o_first_err_addr,
    output logic              o_led
);
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   LAST_IDX = (ADDR_W+1)'(NUM_WORDS - 1);

    function automatic logic [DATA_W-1:0] f_pat(logic [1:0] m, logic [ADDR_W-1:0] a,
                                                 logic [ADDR_W:0] i);
        logic [DATA_W-1:0] p;
        p = '0;
        case (m)
            MODE_CONST: for (int b = 0; b < DATA_W; b++) p[b] = CONST_BYTE[b % 8];
            MODE_ADDR:  p = DATA_W'(a);
            MODE_WALK:  p = DATA_W'(1) << (32'(i) % DATA_W);
            MODE_NADDR: p = ~DATA_W'(a);
        endcase
        return p;
    endfunction

    state_t            r_state;
    logic [1:0]        r_mode;
    logic              r_wr, r_rd, r_busy, r_done, r_pass, r_led, r_stop;
    logic [ADDR_W-1:0] r_addr, r_first;
    logic [ADDR_W:0]   r_idx;
    logic [DATA_W-1:0] r_wdata, r_rdata;
    logic [ERR_W-1:0]  r_err;

    logic [ADDR_W-1:0] w_next_addr;
    logic [ADDR_W:0]   w_next_idx;
    logic              w_last, w_stop, w_mismatch, w_tog;

    // Address wraps naturally at ADDR_W bits; index is one bit wider so NUM_WORDS=2^ADDR_W fits.
    assign w_next_addr = r_addr + 1'b1;
    assign w_next_idx  = r_idx + 1'b1;
    assign w_last      = (r_idx == LAST_IDX);
    assign w_stop      = r_stop | i_stop;
    assign w_mismatch  = (r_rdata != f_pat(r_mode, r_addr, r_idx));

    sdram_bist_blink #(.PERIOD(BLINK_DIV)) u_blink (
        .clk   (clk),
        .rst   (rst),
        .i_en  (r_pass & ~r_busy),
        .o_tog (w_tog)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_mode  <= MODE_CONST;
            r_wr    <= 1'b0;
            r_rd    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_led   <= 1'b0;
            r_stop  <= 1'b0;
            r_addr  <= BASE;
            r_first <= '0;
            r_idx   <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= '0;
        end else begin
            r_done <= 1'b0;
            r_led  <= r_busy | (r_pass & w_tog);
            // Stop is remembered so it takes effect once the open handshake finishes.
            if (r_state != S_IDLE && i_stop) r_stop <= 1'b1;
            case (r_state)
                S_IDLE: if (i_start) begin
                    r_mode  <= i_mode;
                    r_err   <= '0;
                    r_first <= '0;
                    r_addr  <= BASE;
                    r_idx   <= '0;
                    r_wdata <= f_pat(i_mode, BASE, '0);
                    r_wr    <= 1'b1;
                    r_busy  <= 1'b1;
                    r_stop  <= 1'b0;
                    r_state <= S_WRITE;
                end
                S_WRITE: if (bus.wr_ack) begin
                    r_addr <= w_next_addr;
                    r_idx  <= w_next_idx;
                    if (w_stop) begin
                        r_wr    <= 1'b0;
                        r_state <= S_FINISH;
                    end else if (w_last) begin
                        r_wr    <= 1'b0;
                        r_rd    <= 1'b1;
                        r_addr  <= BASE;
                        r_idx   <= '0;
                        r_state <= S_READ;
                    end else begin
                        r_wdata <= f_pat(r_mode, w_next_addr, w_next_idx);
                    end
                end
                S_READ: if (bus.rd_valid) begin
                    r_rdata <= bus.rdata;
                    r_rd    <= 1'b0;
                    r_state <= S_CHECK;
                end
                S_CHECK: begin
                    if (w_mismatch) begin
                        if (r_err != '1) r_err <= r_err + 1'b1;
                        if (r_err == '0) r_first <= r_addr;
                    end
                    if (w_stop || w_last) begin
                        r_state <= S_FINISH;
                    end else begin
                        r_addr  <= w_next_addr;
                        r_idx   <= w_next_idx;
                        r_rd    <= 1'b1;
                        r_state <= S_READ;
                    end
                end
                S_FINISH: begin
                    r_done <= 1'b1;
                    r_pass <= (r_err == '0);
                    r_stop <= 1'b0;
                    if (i_loop_en && !w_stop) begin
                        r_addr  <= BASE;
                        r_idx   <= '0;
                        r_wdata <= f_pat(r_mode, BASE, '0);
                        r_wr    <= 1'b1;
                        r_state <= S_WRITE;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.wr_req       = r_wr;
    assign bus.rd_req       = r_rd;
    assign bus.addr         = r_addr;
    assign bus.wdata        = r_wdata;
    assign o_busy           = r_busy;
    assign o_done           = r_done;
    assign o_pass           = r_pass;
    assign o_err_count      = r_err;
    assign o_first_err_addr = r_first;
    assign o_led            = r_led;
endmodule

// File: tb/tb_sdram_bist.sv
// Bench for sdram_bist: memory model with fault injection, transaction scoreboard, vector table.
module tb_sdram_bist;
    localparam int DW = 16, AW = 22, NW = 20, BDIV = 4;
    localparam logic [21:0] BASE_A = 22'h3FFFFE;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic start, loop_en, stop;
    logic [1:0] mode;
    logic busy, done, pass, led;
    logic [15:0] err;
    logic [21:0] ferr;

    logic s_start, s_loop, s_stop;
    logic [1:0] s_mode;
    logic s_busy, s_done, s_pass, s_led;
    logic [2:0] s_err;
    logic [21:0] s_ferr;

    sdram_bist_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
    sdram_bist_if #(.DATA_W(DW), .ADDR_W(AW)) s_bus ();

    sdram_bist #(.DATA_W(DW), .ADDR_W(AW), .BASE_ADDR(32'h003FFFFE), .NUM_WORDS(NW),
                 .ERR_W(16), .BLINK_DIV(BDIV)) dut (
        .clk(clk), .rst(rst), .i_start(start), .i_mode(mode), .i_loop_en(loop_en),
        .i_stop(stop), .bus(bus), .o_busy(busy), .o_done(done), .o_pass(pass),
        .o_err_count(err), .o_first_err_addr(ferr), .o_led(led));

    sdram_bist #(.DATA_W(DW), .ADDR_W(AW), .BASE_ADDR(0), .NUM_WORDS(NW),
                 .ERR_W(3), .BLINK_DIV(BDIV)) dut_sat (
        .clk(clk), .rst(rst), .i_start(s_start), .i_mode(s_mode), .i_loop_en(s_loop),
        .i_stop(s_stop), .bus(s_bus), .o_busy(s_busy), .o_done(s_done), .o_pass(s_pass),
        .o_err_count(s_err), .o_first_err_addr(s_ferr), .o_led(s_led));

    int npass = 0, ntot = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Independent expected pattern for the 16-bit configuration.
    function automatic logic [15:0] pat(input int m, input logic [21:0] a, input int i);
        case (m)
            0:       return 16'hA5A5;
            1:       return a[15:0];
            2:       return 16'h0001 << (i % 16);
            default: return ~a[15:0];
        endcase
    endfunction

    typedef struct {bit is_rd; logic [21:0] a; logic [15:0] d;} txn_t;
    txn_t sbq[$];
    bit sb_en = 0;

    task automatic push_expect(input int m);
        logic [21:0] a;
        txn_t t;
        sbq.delete();
        for (int k = 0; k < NW; k++) begin
            a = BASE_A + 22'(k);
            t.is_rd = 0; t.a = a; t.d = pat(m, a, k);
            sbq.push_back(t);
        end
        for (int k = 0; k < NW; k++) begin
            t.is_rd = 1; t.a = BASE_A + 22'(k); t.d = '0;
            sbq.push_back(t);
        end
    endtask

    task automatic sb_check(input bit is_rd, input logic [21:0] a, input logic [15:0] d);
        txn_t e;
        if (!sb_en) return;
        if (sbq.size() == 0) begin
            chk("sb_underflow", 0, 1);
            return;
        end
        e = sbq.pop_front();
        chk("sb_kind", is_rd, e.is_rd);
        chk("sb_addr", a, e.a);
        if (!is_rd) chk("sb_wdata", d, e.d);
    endtask

    // Memory model: acks after 2 cycles, optional fault: 1 = flip bit 0 at flt_addr, 2 = stuck-at-0.
    logic [15:0] mem [logic [21:0]];
    int flt_mode = 0;
    logic [21:0] flt_addr = '0;
    bit hold = 0;
    int cnt = 0, proto_viol = 0;
    logic prev_wr = 0, prev_ack = 0, prev_rd = 0, prev_vld = 0;

    always @(posedge clk) begin
        if (rst) begin
            bus.wr_ack <= 1'b0; bus.rd_valid <= 1'b0; bus.rdata <= '0;
            cnt = 0; prev_wr = 0; prev_ack = 0; prev_rd = 0; prev_vld = 0;
        end else begin
            bus.wr_ack <= 1'b0; bus.rd_valid <= 1'b0;
            if (bus.wr_req && bus.rd_req) proto_viol++;
            if (prev_wr && !prev_ack && !bus.wr_req) proto_viol++;
            if (prev_rd && !prev_vld && !bus.rd_req) proto_viol++;
            prev_wr = bus.wr_req; prev_ack = bus.wr_ack;
            prev_rd = bus.rd_req; prev_vld = bus.rd_valid;
            if ((bus.wr_req || bus.rd_req) && !bus.wr_ack && !bus.rd_valid && !hold) begin
                if (cnt == 1) begin
                    cnt = 0;
                    if (bus.wr_req) begin
                        bus.wr_ack <= 1'b1;
                        mem[bus.addr] = bus.wdata;
                        sb_check(0, bus.addr, bus.wdata);
                    end else begin
                        bus.rd_valid <= 1'b1;
                        if (flt_mode == 2) bus.rdata <= '0;
                        else if (flt_mode == 1 && bus.addr == flt_addr) bus.rdata <= mem[bus.addr] ^ 16'h1;
                        else bus.rdata <= mem[bus.addr];
                        sb_check(1, bus.addr, '0);
                    end
                end else cnt++;
            end
        end
    end

    // Saturation instance sees a stuck-at-0 memory that acks every request immediately.
    assign s_bus.rdata = '0;
    always @(posedge clk) begin
        if (rst) begin
            s_bus.wr_ack <= 1'b0; s_bus.rd_valid <= 1'b0;
        end else begin
            s_bus.wr_ack   <= s_bus.wr_req & ~s_bus.wr_ack;
            s_bus.rd_valid <= s_bus.rd_req & ~s_bus.rd_valid;
        end
    end

    typedef struct {int mode; int flt; logic [21:0] faddr;
                    logic [15:0] exp_err; logic [21:0] exp_first; bit exp_pass;} vec_t;
    vec_t vecs[6];

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 3000) begin @(negedge clk); n++; end
        if (!done) chk(name, 0, 1);
    endtask

    initial begin
        bit seen0, seen1, reqseen;
        int n;
        vecs[0] = '{1, 0, 22'h0,      16'd0,  22'h0,      1'b1};
        vecs[1] = '{0, 1, 22'h5,      16'd1,  22'h5,      1'b0};
        vecs[2] = '{2, 2, 22'h0,      16'd20, 22'h3FFFFE, 1'b0};
        vecs[3] = '{3, 0, 22'h0,      16'd0,  22'h0,      1'b1};
        vecs[4] = '{1, 1, 22'h3FFFFF, 16'd1,  22'h3FFFFF, 1'b0};
        vecs[5] = '{2, 0, 22'h0,      16'd0,  22'h0,      1'b1};

        rst = 1; start = 0; loop_en = 0; stop = 0; mode = 0;
        s_start = 0; s_loop = 0; s_stop = 0; s_mode = 2;
        repeat (3) @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk("rst_busy", busy, 0);   chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);   chk("rst_err", err, 0);
        chk("rst_first", ferr, 0);  chk("rst_led", led, 0);
        chk("rst_wr", bus.wr_req, 0); chk("rst_rd", bus.rd_req, 0);
        chk("rst_addr", bus.addr, BASE_A); chk("rst_wdata", bus.wdata, 0);

        stop = 1; @(negedge clk); stop = 0; @(negedge clk);
        chk("stop_idle_busy", busy, 0);

        foreach (vecs[v]) begin
            flt_mode = vecs[v].flt; flt_addr = vecs[v].faddr;
            push_expect(vecs[v].mode); sb_en = 1;
            mode = 2'(vecs[v].mode); start = 1; @(negedge clk); start = 0;
            repeat (3) @(negedge clk);
            chk("run_busy", busy, 1); chk("run_led", led, 1);
            mode = 2'(vecs[v].mode) ^ 2'd1; start = 1; @(negedge clk); start = 0;
            wait_done("done_timeout");
            chk("vec_err", err, vecs[v].exp_err);
            chk("vec_first", ferr, vecs[v].exp_first);
            chk("vec_pass", pass, vecs[v].exp_pass);
            chk("vec_busy", busy, 0);
            chk("vec_sb_left", sbq.size(), 0);
            seen0 = 0; seen1 = 0;
            for (int c = 0; c < 12; c++) begin
                @(negedge clk);
                if (c == 0) chk("done_pulse", done, 0);
                if (led) seen1 = 1; else seen0 = 1;
            end
            if (vecs[v].exp_pass) chk("led_blink", {seen0, seen1}, 2'b11);
            else chk("led_off", seen1, 0);
        end

        // Loop mode, then stop during second-pass read.
        sb_en = 0; flt_mode = 0; loop_en = 1; mode = 1;
        start = 1; @(negedge clk); start = 0;
        wait_done("loop_done1_timeout");
        chk("loop_pass1", pass, 1); chk("loop_busy1", busy, 1);
        n = 0;
        while (!bus.rd_req && n < 3000) begin @(negedge clk); n++; end
        chk("loop_rd_seen", bus.rd_req, 1);
        stop = 1; @(negedge clk); stop = 0;
        wait_done("loop_done2_timeout");
        chk("loop_pass2", pass, 1); chk("loop_err2", err, 0);
        @(negedge clk);
        chk("loop_idle", busy, 0);
        reqseen = 0;
        repeat (40) begin @(negedge clk); if (bus.wr_req || bus.rd_req) reqseen = 1; end
        chk("loop_no_req", reqseen, 0);
        loop_en = 0;

        // ERR_W=3 saturation, walking-one against stuck-at-0.
        s_start = 1; @(negedge clk); s_start = 0;
        n = 0;
        while (!s_done && n < 3000) begin @(negedge clk); n++; end
        chk("sat_done", s_done, 1);
        chk("sat_err", s_err, 3'd7); chk("sat_first", s_ferr, 0); chk("sat_pass", s_pass, 0);

        chk("protocol", proto_viol, 0);

        // Reset while a write is pending with ack withheld.
        hold = 1; mode = 1; start = 1; @(negedge clk); start = 0;
        repeat (3) @(negedge clk);
        chk("hold_wr", bus.wr_req, 1);
        rst = 1; @(negedge clk);
        chk("mid_wr", bus.wr_req, 0); chk("mid_rd", bus.rd_req, 0);
        chk("mid_busy", busy, 0);     chk("mid_pass", pass, 0);
        chk("mid_addr", bus.addr, BASE_A); chk("mid_wdata", bus.wdata, 0);
        chk("mid_err", err, 0); chk("mid_led", led, 0); chk("mid_done", done, 0);
        rst = 0; hold = 0;
        @(negedge clk);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
